board_renderer: RTL
===================

// Module: board_renderer
// PURPOSE
// - Reader of the 64-bit board state (16 x 4-bit tile exponents) that the game controller writes into the box registers.
// - On request, snapshots the board and rasterises 16 solid-colour tiles into the 160x120 VGA framebuffer adapter, one pixel per cycle (x/y/colour/plot).
// - Sits between the game core (board, draw request from control) and the VGA adapter.
// PARAMETERS
// TILE     28  tile edge in pixels (square)
// PITCH    30  tile-to-tile spacing in pixels; gap = PITCH-TILE, never written
// X0       20  x of tile 0 top-left pixel
// Y0       0   y of tile 0 top-left pixel
// X_W      8   width of x output
// Y_W      7   width of y output
// COLOR_W  3   width of colour output
// PORTS
// clock     in   1        system clock; all logic on rising edge
// reset_n   in   1        asynchronous active-low reset
// board     in   64       box1 in [63:60] ... box16 in [3:0]; row-major, box1 = top-left
// draw_req  in   1        start a render pass (level or pulse; sampled only in IDLE)
// x         out  X_W      pixel x
// y         out  Y_W      pixel y
// colour    out  COLOR_W  pixel colour
// plot      out  1        x/y/colour valid this cycle; adapter writes on every plot=1 cycle
// busy      out  1        high from acceptance until done
// done      out  1        one-cycle pulse after last pass cycle
// BEHAVIOUR
// - Reset (async, reset_n=0): state IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0; tile/pixel counters 0.
// - States: IDLE -> LOAD -> SCAN -> DRAW -> (SCAN | FIN) -> IDLE.
// - IDLE: draw_req=1 at an edge -> LOAD; busy=1 from the next cycle.
// - LOAD (1 cycle): board copied to a snapshot register; later board changes do not affect the pass. t=0.
// - SCAN (1 cycle/tile, plot=0): latch v = snapshot nibble t; px=py=0; -> DRAW (or skip, see CONFIGURATION).
// - DRAW (TILE*TILE cycles, plot=1): r=t[3:2], c=t[1:0]; x = X0 + c*PITCH + px; y = Y0 + r*PITCH + py.
//   - px increments fastest, wraps at TILE-1 while py increments.
//   - After px=py=TILE-1: t<15 -> t+1, SCAN; t=15 -> FIN.
// - Colour: v==0 -> 0 (black); else ((v-1) mod 7) + 1, never 0. Exponents 1,8,15 -> 1; 7,14 -> 7.
// - FIN (1 cycle): plot=0, done=1, busy=0 the next cycle -> IDLE.
// - x/y/colour are registered with plot; values outside plot=1 cycles are don't-care but must not be X after reset.
// - Full pass latency: req edge -> first plot at edge +3 (LOAD, SCAN); total busy = 1 + 16*(1+TILE*TILE) + 1 cycles
//   = 12562 at defaults.
// - draw_req while busy is ignored, not queued; held high through FIN starts a new pass on the first IDLE cycle.
// - Max coordinates at defaults: x = 20+90+27 = 137, y = 117; within 160x120, no wrap.
// - reset_n low mid-pass: immediate abort to reset values; no done pulse; partial frame left as is.
// CONFIGURATION
// - DIRTY_TILE_EN defined: keeps a 64-bit shadow of last-drawn values plus 16 valid bits (reset to 0).
//   - In SCAN, tile t is skipped (SCAN -> next SCAN/FIN, 1 cycle, no plot) when valid[t]=1 and shadow[t]==v.
//   - Shadow/valid for tile t are updated on completion of its DRAW only.
//   - An aborted pass (reset) clears all valid bits.
// - DIRTY_TILE_EN undefined: no shadow; every tile is drawn every pass; latency fixed as above.
// TESTING
// - Reset, then req with board=64'h0 -> 12544 plot cycles, all colour 0; first pixel (20,0); last pixel (137,117); done once.
// - board = 64'h0123456789ABCDEF -> tile t uses colour map of exponent t; check tile 5 (row1,col1) at (50..77, 30..57) colour 5;
//   tile 8 colour 1.
// - Change board one cycle after LOAD -> output still reflects snapshot; req pulses during busy -> exactly one done.
// - reset_n low at plot cycle 5000 -> plot, busy, done low asynchronously; a new req then gives a full 12562-cycle pass.
// - DIRTY_TILE_EN: two passes with identical board -> second pass 0 plots, busy 1+16+1 = 18 cycles;
//   change box7 only -> exactly 784 plots at x 80..107, y 30..57.
// - Gap check: no plot ever at x in {48,49,78,79,108,109} or y in {28,29,58,59,88,89}.

Source files
------------

// File: rtl/board_renderer.sv
// -----------------------------------------------------------------------------
// board_renderer
//
// Purpose:
//   Snapshots the 64-bit game board (16 x 4-bit tile exponents, box1 in
//   [63:60], row-major, box1 top-left) on request. It then rasterises the
//   16 solid-colour square tiles into a 160x120 VGA framebuffer adapter,
//   one pixel per clock.
//
//   Pass sequence: IDLE -> LOAD -> (SCAN -> DRAW) x16 -> FIN -> IDLE.
//
// Optional feature (compile-time macro DIRTY_TILE_EN):
//   Keeps a shadow copy of the last-drawn exponent per tile plus a valid bit.
//   A tile whose exponent is unchanged since its last completed draw is
//   skipped in one SCAN cycle with no plot. Without the macro every tile is
//   drawn on every pass.
//
// Ports:
//   clock     in   1        system clock, rising edge
//   reset_n   in   1        asynchronous active-low reset
//   board     in   64       tile exponents, box1 in [63:60] ... box16 in [3:0]
//   draw_req  in   1        start a pass (sampled only while idle)
//   x         out  X_W      pixel x
//   y         out  Y_W      pixel y
//   colour    out  COLOR_W  pixel colour
//   plot      out  1        x/y/colour valid this cycle
//   busy      out  1        high from acceptance until the pass ends
//   done      out  1        one-cycle pulse in the final pass cycle
// -----------------------------------------------------------------------------
module board_renderer #(
    parameter int TILE    = 28,
    parameter int PITCH   = 30,
    parameter int X0      = 20,
    parameter int Y0      = 0,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [63:0]        board,
    input  logic               draw_req,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] colour,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    localparam int PIX_W = $clog2(TILE);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(TILE - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_DRAW, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [63:0]        snap_q, snap_d;
    logic [3:0]         t_q, t_d;
    logic [3:0]         v_q, v_d;
    logic [PIX_W-1:0]   px_q, px_d, py_q, py_d;

    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0] colour_q, colour_d;
    logic               plot_q, plot_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Exponent 0 is black. Others cycle through colours 1..7 so no tile with a
    // value is ever drawn black.
    function automatic logic [COLOR_W-1:0] colour_of(input logic [3:0] e);
        logic [3:0] m;
        m = (e - 4'd1) % 4'd7;
        if (e == 4'd0) return '0;
        return COLOR_W'(m) + COLOR_W'(1);
    endfunction

    // box1 (t=0) lives in the top nibble, so the LSB of tile t is (15-t)*4.
    logic [5:0] nib_lsb;
    logic [3:0] nib;
    assign nib_lsb = {~t_q, 2'b00};
    assign nib     = snap_q[nib_lsb +: 4];

    logic tile_done;
    assign tile_done = (state_q == S_DRAW) && (px_q == PIX_LAST) && (py_q == PIX_LAST);

`ifdef DIRTY_TILE_EN
    logic [63:0] shadow_q;
    logic [15:0] valid_q;
    logic        skip;
    assign skip = valid_q[t_q] && (shadow_q[nib_lsb +: 4] == nib);
`else
    logic        skip;
    assign skip = 1'b0;
`endif

    // State register and control counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            px_q     <= '0;
            py_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            px_q     <= px_d;
            py_q     <= py_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Snapshot and current tile value: only read after LOAD/SCAN write them
    always_ff @(posedge clock) begin
        snap_q <= snap_d;
        v_q    <= v_d;
    end

`ifdef DIRTY_TILE_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (tile_done) begin
            valid_q[t_q] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (tile_done) begin
            shadow_q[nib_lsb +: 4] <= v_q;
        end
    end
`endif

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        t_d     = t_q;
        v_d     = v_q;
        px_d    = px_q;
        py_d    = py_q;
        unique case (state_q)
            S_IDLE: begin
                if (draw_req) state_d = S_LOAD;
            end
            S_LOAD: begin
                snap_d  = board;
                t_d     = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                v_d  = nib;
                px_d = '0;
                py_d = '0;
                if (!skip) begin
                    state_d = S_DRAW;
                end else if (t_q == 4'd15) begin
                    state_d = S_FIN;
                end else begin
                    t_d = t_q + 4'd1;
                end
            end
            S_DRAW: begin
                if (px_q != PIX_LAST) begin
                    px_d = px_q + PIX_W'(1);
                end else begin
                    px_d = '0;
                    if (py_q != PIX_LAST) begin
                        py_d = py_q + PIX_W'(1);
                    end else if (t_q == 4'd15) begin
                        state_d = S_FIN;
                    end else begin
                        t_d     = t_q + 4'd1;
                        state_d = S_SCAN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with
    // the state they describe; coordinates are forced to 0 outside DRAW.
    always_comb begin
        plot_d   = (state_d == S_DRAW);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_FIN);
        x_d      = '0;
        y_d      = '0;
        colour_d = '0;
        if (plot_d) begin
            x_d      = X_W'(X0 + int'(t_d[1:0]) * PITCH + int'(px_d));
            y_d      = Y_W'(Y0 + int'(t_d[3:2]) * PITCH + int'(py_d));
            colour_d = colour_of(v_d);
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
